kf_seq_loop: RTL and testbench
==============================

Name: kf_seq_loop

Overview:
- Second-generation microcode sequencer for the Kalman filter datapath.
- Fetches instructions from an internal, port-programmable ROM and drives router, memory and arithmetic-unit (AU) control fields.
- Stalls on AU completion and reports READY.
- Relative to the first-generation sequencer, adds:
  - parametrised PC and address widths;
  - a hardware LOOP instruction backed by a loop counter;
  - a synchronous abort;
  - a write-protected ROM while running.

Parameters:
- ADDRW, 5: width of the a/b address fields. Also the width of the LOOP target and count. Must be <= PCW.
- PCW, 8: program counter width. ROM depth is 2^PCW words.
- IW, 2*ADDRW+6: instruction width, packed as {a[ADDRW], b[ADDRW], c[2], d[2], e, f}, MSB first.
- TIMEOUT, 1024: maximum WAIT stall in cycles. Used only with the optional feature.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin execution at PC=0; sampled only in IDLE
- abort  in  1  synchronous return to IDLE from any state
- continue_i  in  1  AU done; releases a WAIT instruction
- rom_we  in  1  ROM write strobe
- rom_waddr  in  PCW  ROM write address
- rom_wdata  in  IW  ROM write data
- ready  out  1  high in IDLE
- pc  out  PCW  current program counter
- ctl_a  out  ADDRW  field a of the current instruction
- ctl_b  out  ADDRW  field b of the current instruction
- ctl_c  out  2  opcode: 00 INC, 01 WAIT, 10 HALT, 11 LOOP
- ctl_d  out  2  AU operation select
- ctl_e  out  1  AU start
- ctl_f  out  1  data-bank write enable
- loop_active  out  1  loop counter is armed
- err  out  1  sticky WAIT-timeout flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, pc=0, lc=0, loop_active=0, err=0, ready=1.
  - ROM contents are not reset.
- ready is 1 in IDLE and 0 in RUN.
- ROM write:
  - Accepted on a clock edge with rom_we=1 only in IDLE.
  - rom_we in RUN is ignored; the ROM is unchanged.
- ROM read is combinational: inst = rom[pc].
- Control outputs:
  - In RUN, ctl_* = fields of inst.
  - In IDLE, all ctl_* are 0.
  - While a WAIT instruction is stalled, ctl_e and ctl_f are forced to 0 on every stalled cycle after the first, so the AU start and bank write are issued exactly once.
- IDLE: start=1 on an edge moves to RUN with pc=0 on the next cycle, ready=0. start in RUN is ignored.
- RUN, per-cycle execution by opcode:
  - INC: pc <= pc+1. Wraps from 2^PCW-1 to 0.
  - WAIT: if continue_i=1, pc <= pc+1; otherwise pc holds. continue_i high in the first WAIT cycle advances immediately (single-cycle WAIT).
  - HALT: state <= IDLE, pc <= 0, lc <= 0, loop_active <= 0. ready=1 from the next cycle.
  - LOOP (target T = zero-extended a, count N = b):
    - loop_active=0, N=0: pc <= pc+1 (no loop).
    - loop_active=0, N>0: lc <= N-1, loop_active <= 1, pc <= T.
    - loop_active=1, lc>0: lc <= lc-1, pc <= T.
    - loop_active=1, lc=0: loop_active <= 0, pc <= pc+1.
    - Net effect: the body from T to the LOOP instruction executes N+1 times in total.
    - Loops do not nest; a LOOP encountered while armed uses the single counter.
- abort=1 on an edge in any state:
  - Same effect as HALT: IDLE, pc=0, lc cleared, loop_active=0.
  - err is not cleared.
  - abort has priority over start, HALT, LOOP and continue_i.
- Simultaneous start and rom_we in IDLE: the write is performed and the run begins.
- err is cleared only by reset or by the next accepted start.

Optional Feature:
- Macro: KF_SEQ_WAIT_TIMEOUT_EN.
- Defined:
  - A wait counter resets on entry to each WAIT instruction and counts every stalled cycle.
  - When the count reaches TIMEOUT without continue_i, the block sets err=1 and behaves as HALT (IDLE, pc=0).
- Not defined:
  - No counter exists and err is tied to 0.
  - WAIT stalls indefinitely.

Test Plan:
- Program ROM[0..5] = {INC f=1 a=0}, {INC f=1 a=1}, {INC e=1 a=0 b=1}, {WAIT}, {INC f=1 a=2}, {HALT}. Pulse start; assert continue_i 3 cycles after pc=3.
  - Required: pc sequence 0,1,2,3,3,3,3,4,5,0.
  - Required: ctl_e=1 only at pc=2.
  - Required: ready returns to 1 the cycle after HALT.
- LOOP with a=1, b=3 at pc=3, body at pc=1..2.
  - Required: pc=1 visited 4 times.
  - Required: loop_active high from the first jump until the final fall-through to pc=4.
- Assert abort while stalled in WAIT at pc=3.
  - Required: next cycle ready=1, pc=0, all ctl_*=0.
  - Required: a subsequent start reruns from pc=0.
- rom_we to address 0 during RUN, then HALT and read back.
  - Required: ROM[0] unchanged.
  - Required: the same write issued in IDLE takes effect.
- PCW=3, program of eight INC instructions.
  - Required: pc wraps 7 to 0 and execution continues until abort.
- With KF_SEQ_WAIT_TIMEOUT_EN and TIMEOUT=16, WAIT with continue_i held low.
  - Required: err=1 and ready=1 after 16 stall cycles.
  - Required: err clears on the next accepted start.

Source files
------------

// File: rtl/kf_seq_loop.sv
// kf_seq_loop: microcode sequencer with port-programmed ROM, WAIT stall, hardware LOOP and abort.
// Define KF_SEQ_WAIT_TIMEOUT_EN to add a WAIT timeout that halts the program and raises err.
module kf_seq_loop #(
  parameter int ADDRW   = 5,
  parameter int PCW     = 8,
  parameter int IW      = 2*ADDRW+6,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             continue_i,
  input  logic             rom_we,
  input  logic [PCW-1:0]   rom_waddr,
  input  logic [IW-1:0]    rom_wdata,
  output logic             ready,
  output logic [PCW-1:0]   pc,
  output logic [ADDRW-1:0] ctl_a,
  output logic [ADDRW-1:0] ctl_b,
  output logic [1:0]       ctl_c,
  output logic [1:0]       ctl_d,
  output logic             ctl_e,
  output logic             ctl_f,
  output logic             loop_active,
  output logic             err
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [1:0] OP_INC = 2'd0, OP_WAIT = 2'd1, OP_HALT = 2'd2, OP_LOOP = 2'd3;
  state_t           state_q, state_d;
  logic [PCW-1:0]   pc_q, pc_d, pc_inc, target;
  logic [ADDRW-1:0] lc_q, lc_d;
  logic             la_q, la_d, stall_q, stall_d, halt, run, tmo;
  logic [IW-1:0]    rom_q [2**PCW];
  logic [IW-1:0]    inst;
  logic [ADDRW-1:0] op_a, op_b;
  logic [1:0]       op_c, op_d;
  logic             op_e, op_f;
  assign inst = rom_q[pc_q];
  assign {op_a, op_b, op_c, op_d, op_e, op_f} = inst;
  assign run    = state_q == RUN;
  assign pc_inc = pc_q + 1'b1;
  assign target = PCW'(op_a);
  assign ready       = !run;
  assign pc          = pc_q;
  assign loop_active = la_q;
  assign ctl_a = run ? op_a : '0;
  assign ctl_b = run ? op_b : '0;
  assign ctl_c = run ? op_c : '0;
  assign ctl_d = run ? op_d : '0;
  // stall_q marks repeat cycles of a held WAIT, so AU start and bank write fire once
  assign ctl_e = run && op_e && !stall_q;
  assign ctl_f = run && op_f && !stall_q;
`ifdef KF_SEQ_WAIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] wcnt_q, wcnt_d, wcnt_n;
  logic          err_q, err_d;
  assign wcnt_n = stall_q ? wcnt_q + 1'b1 : TW'(1);
  assign tmo    = run && op_c == OP_WAIT && !continue_i && wcnt_n == TW'(TIMEOUT);
  assign err    = err_q;
  always_comb begin
    wcnt_d = stall_d ? wcnt_n : '0;
    err_d  = (tmo && !abort) ? 1'b1 : (!run && start && !abort) ? 1'b0 : err_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
`else
  assign tmo = 1'b0;
  assign err = 1'b0 & (TIMEOUT > 0);
`endif
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    lc_d    = lc_q;
    la_d    = la_q;
    stall_d = 1'b0;
    halt    = abort || tmo;
    if (!run) begin
      if (start) begin
        state_d = RUN;
        pc_d    = '0;
      end
    end else begin
      case (op_c)
        OP_INC:  pc_d = pc_inc;
        OP_WAIT: if (continue_i) pc_d = pc_inc; else stall_d = 1'b1;
        OP_HALT: halt = 1'b1;
        OP_LOOP: begin
          if (!la_q && op_b == '0) pc_d = pc_inc;
          else if (!la_q) begin
            lc_d = op_b - 1'b1;
            la_d = 1'b1;
            pc_d = target;
          end else if (lc_q != '0) begin
            lc_d = lc_q - 1'b1;
            pc_d = target;
          end else begin
            la_d = 1'b0;
            pc_d = pc_inc;
          end
        end
      endcase
    end
    if (halt) begin
      state_d = IDLE;
      pc_d    = '0;
      lc_d    = '0;
      la_d    = 1'b0;
      stall_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      lc_q    <= '0;
      la_q    <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lc_q    <= lc_d;
      la_q    <= la_d;
      stall_q <= stall_d;
    end
  always_ff @(posedge clk)
    if (rom_we && !run) rom_q[rom_waddr] <= rom_wdata;
endmodule

// File: tb/tb_kf_seq_loop.sv
// tb_kf_seq_loop: table-driven scoreboard bench for kf_seq_loop, plus a PCW=3 wrap instance.
module tb_kf_seq_loop;
  localparam int AW = 5, PW = 8, IWD = 2*AW+6;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start, abort, continue_i, rom_we;
  logic [PW-1:0] rom_waddr;
  logic [IWD-1:0] rom_wdata;
  logic ready, loop_active, err, ctl_e, ctl_f;
  logic [PW-1:0] pc;
  logic [AW-1:0] ctl_a, ctl_b;
  logic [1:0] ctl_c, ctl_d;
  logic start3, abort3, we3, ready3, la3, err3, e3, f3;
  logic [2:0] waddr3, pc3, a3, b3;
  logic [11:0] wdata3;
  logic [1:0] c3, d3;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  kf_seq_loop #(.ADDRW(AW), .PCW(PW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .continue_i(continue_i),
    .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata), .ready(ready), .pc(pc),
    .ctl_a(ctl_a), .ctl_b(ctl_b), .ctl_c(ctl_c), .ctl_d(ctl_d), .ctl_e(ctl_e), .ctl_f(ctl_f),
    .loop_active(loop_active), .err(err));

  kf_seq_loop #(.ADDRW(3), .PCW(3), .TIMEOUT(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .continue_i(1'b0),
    .rom_we(we3), .rom_waddr(waddr3), .rom_wdata(wdata3), .ready(ready3), .pc(pc3),
    .ctl_a(a3), .ctl_b(b3), .ctl_c(c3), .ctl_d(d3), .ctl_e(e3), .ctl_f(f3),
    .loop_active(la3), .err(err3));

  typedef struct {
    logic st, co, ab, we;
    logic [15:0] wd;
    logic [7:0] pc;
    logic rdy;
    logic [15:0] ctl;
    logic la;
  } vec_t;
  typedef struct {
    logic [7:0] pc;
    logic rdy;
    logic [15:0] ctl;
    logic la;
  } exp_t;
  vec_t tv[$];
  exp_t sb[$];
  logic [2:0] q3[$];
  logic [15:0] p0, p1, p2, p3, p4, p5, l0, l1, l2, l3, l4, we_w, wm_w, new_w;

  function automatic logic [15:0] ins(input int a, b, c, d, e, f);
    ins = {a[4:0], b[4:0], c[1:0], d[1:0], e[0], f[0]};
  endfunction

  function automatic vec_t v(input logic st, co, ab, we, input logic [15:0] wd,
                             input logic [7:0] p, input logic r, input logic [15:0] c, input logic l);
    v = '{st, co, ab, we, wd, p, r, c, l};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [15:0] w);
    rom_we = 1'b1; rom_waddr = a[7:0]; rom_wdata = w;
    @(negedge clk);
    rom_we = 1'b0;
  endtask

  task automatic run_vecs(input string name);
    exp_t e;
    foreach (tv[i]) begin
      start = tv[i].st; continue_i = tv[i].co; abort = tv[i].ab;
      rom_we = tv[i].we; rom_waddr = '0; rom_wdata = tv[i].wd;
      sb.push_back(exp_t'{tv[i].pc, tv[i].rdy, tv[i].ctl, tv[i].la});
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("%s[%0d] pc", name, i), pc, e.pc);
      chk($sformatf("%s[%0d] ready", name, i), ready, e.rdy);
      chk($sformatf("%s[%0d] ctl", name, i), {ctl_a, ctl_b, ctl_c, ctl_d, ctl_e, ctl_f}, e.ctl);
      chk($sformatf("%s[%0d] loop_active", name, i), loop_active, e.la);
      chk($sformatf("%s[%0d] err", name, i), err, 1'b0);
    end
    start = 1'b0; continue_i = 1'b0; abort = 1'b0; rom_we = 1'b0;
    tv.delete();
  endtask

  initial begin
    start = 0; abort = 0; continue_i = 0; rom_we = 0; rom_waddr = '0; rom_wdata = '0;
    start3 = 0; abort3 = 0; we3 = 0; waddr3 = '0; wdata3 = '0;
    p0 = ins(0,0,0,0,0,1); p1 = ins(1,0,0,0,0,1); p2 = ins(0,1,0,0,1,0);
    p3 = ins(0,0,1,0,0,0); p4 = ins(2,0,0,0,0,1); p5 = ins(0,0,2,0,0,0);
    l0 = ins(3,4,0,1,0,0); l1 = ins(7,0,0,0,0,1); l2 = ins(9,2,0,3,1,0);
    l3 = ins(1,3,3,0,0,0); l4 = ins(0,0,3,0,0,0);
    we_w = ins(5,6,1,2,1,1); wm_w = ins(5,6,1,2,0,0); new_w = ins(21,10,0,3,0,1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset ready", ready, 1'b1);
    chk("reset pc", pc, 8'd0);
    chk("reset ctl", {ctl_a, ctl_b, ctl_c, ctl_d, ctl_e, ctl_f}, 16'd0);
    chk("reset loop_active", loop_active, 1'b0);
    chk("reset err", err, 1'b0);
    chk("reset ready3", ready3, 1'b1);

    // basic program with a WAIT released three cycles after entry
    wr(0, p0); wr(1, p1); wr(2, p2); wr(3, p3); wr(4, p4); wr(5, p5);
    tv.push_back(v(1,0,0,0,0, 0,0,p0,0));
    tv.push_back(v(0,0,0,0,0, 1,0,p1,0));
    tv.push_back(v(0,0,0,0,0, 2,0,p2,0));
    for (int k = 0; k < 4; k++) tv.push_back(v(0,0,0,0,0, 3,0,p3,0));
    tv[$].co = 1'b0;
    tv.push_back(v(0,1,0,0,0, 4,0,p4,0));
    tv.push_back(v(0,0,0,0,0, 5,0,p5,0));
    tv.push_back(v(0,0,0,0,0, 0,1,0,0));
    tv.push_back(v(0,0,0,0,0, 0,1,0,0));
    run_vecs("prog");

    // LOOP a=1 b=3 then a LOOP with zero count that falls through
    wr(0, l0); wr(1, l1); wr(2, l2); wr(3, l3); wr(4, l4); wr(5, p5);
    tv.push_back(v(1,0,0,0,0, 0,0,l0,0));
    tv.push_back(v(0,0,0,0,0, 1,0,l1,0));
    tv.push_back(v(0,0,0,0,0, 2,0,l2,0));
    tv.push_back(v(0,0,0,0,0, 3,0,l3,0));
    for (int k = 0; k < 3; k++) begin
      tv.push_back(v(0,0,0,0,0, 1,0,l1,1));
      tv.push_back(v(0,0,0,0,0, 2,0,l2,1));
      tv.push_back(v(0,0,0,0,0, 3,0,l3,1));
    end
    tv.push_back(v(0,0,0,0,0, 4,0,l4,0));
    tv.push_back(v(0,0,0,0,0, 5,0,p5,0));
    tv.push_back(v(0,0,0,0,0, 0,1,0,0));
    run_vecs("loop");

    // abort while stalled in a WAIT that issues e/f once
    wr(3, we_w); wr(4, p5);
    tv.push_back(v(1,0,0,0,0, 0,0,l0,0));
    tv.push_back(v(0,0,0,0,0, 1,0,l1,0));
    tv.push_back(v(0,0,0,0,0, 2,0,l2,0));
    tv.push_back(v(0,0,0,0,0, 3,0,we_w,0));
    tv.push_back(v(0,0,0,0,0, 3,0,wm_w,0));
    tv.push_back(v(0,0,0,0,0, 3,0,wm_w,0));
    tv.push_back(v(0,1,1,0,0, 0,1,0,0));
    tv.push_back(v(1,0,0,0,0, 0,0,l0,0));
    tv.push_back(v(0,0,0,0,0, 1,0,l1,0));
    tv.push_back(v(0,0,1,0,0, 0,1,0,0));
    tv.push_back(v(1,0,1,0,0, 0,1,0,0));
    run_vecs("abort");

    // ROM write ignored in RUN, accepted in IDLE together with start
    wr(1, p5);
    tv.push_back(v(1,0,0,0,0,     0,0,l0,0));
    tv.push_back(v(0,0,0,1,new_w, 1,0,p5,0));
    tv.push_back(v(0,0,0,0,0,     0,1,0,0));
    tv.push_back(v(1,0,0,0,0,     0,0,l0,0));
    tv.push_back(v(0,0,0,0,0,     1,0,p5,0));
    tv.push_back(v(0,0,0,0,0,     0,1,0,0));
    tv.push_back(v(1,0,0,1,new_w, 0,0,new_w,0));
    tv.push_back(v(0,0,0,0,0,     1,0,p5,0));
    tv.push_back(v(0,0,0,0,0,     0,1,0,0));
    run_vecs("romwp");

    // asynchronous reset mid-cycle
    wr(1, l1); wr(2, p5);
    start = 1'b1; @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("pre-reset pc", pc, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset ready", ready, 1'b1);
    chk("async reset pc", pc, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // PCW=3 wrap with eight INC instructions
    for (int i = 0; i < 8; i++) begin
      we3 = 1'b1; waddr3 = i[2:0]; wdata3 = {i[2:0], 9'd0};
      @(negedge clk);
    end
    we3 = 1'b0;
    start3 = 1'b1;
    for (int k = 0; k < 13; k++) begin
      q3.push_back(3'(k));
      @(negedge clk);
      start3 = 1'b0;
      chk($sformatf("wrap[%0d] pc", k), pc3, q3[0]);
      chk($sformatf("wrap[%0d] ctl_a", k), a3, q3.pop_front());
      chk($sformatf("wrap[%0d] ready", k), ready3, 1'b0);
    end
    abort3 = 1'b1; @(negedge clk); abort3 = 1'b0;
    chk("wrap abort ready", ready3, 1'b1);
    chk("wrap abort pc", pc3, 3'd0);

`ifdef KF_SEQ_WAIT_TIMEOUT_EN
    wr(0, p3); wr(1, p5);
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("tmo stall[%0d] ready", k), ready, 1'b0);
      chk($sformatf("tmo stall[%0d] err", k), err, 1'b0);
      @(negedge clk);
    end
    chk("tmo ready", ready, 1'b1);
    chk("tmo err", err, 1'b1);
    chk("tmo pc", pc, 8'd0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("tmo restart err", err, 1'b0);
    chk("tmo restart ready", ready, 1'b0);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("tmo abort ready", ready, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
